// File: rtl/nibble_serial_adder.sv
// Wide adder sequencer: feeds one nibble per cycle to an external 4-bit
// combinational adder and assembles the W-bit sum, with valid/ready on both sides.
module nibble_serial_adder #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int              IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic [IW-1:0] idx;
    logic [IW+1:0] nib_lsb;
    logic          accept;
    logic          step;
    logic          last;

    assign nib_lsb = {idx, 2'b00};
    assign last    = (idx == LAST_IDX);

    // NOTE: non-blocking assignments for every register so all flops sample
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                busy    = 1'b1;
                step    = 1'b1;
                add_a   = a_reg[nib_lsb +: 4];
                add_b   = b_reg[nib_lsb +: 4];
                add_cin = carry_reg;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand and result registers are reset too; an abort must leave no
    // stale partial sum visible on out_sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            sum_reg   <= '0;
            carry_reg <= in_cin;
            idx       <= '0;
        end else if (step) begin
            sum_reg[nib_lsb +: 4] <= add_sum;
            carry_reg             <= add_cout;
            if (last) begin
                cout_reg <= add_cout;
                idx      <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;

endmodule
